// File: rtl/md_unit_param.sv
// Parametrised multiply/divide unit with private HI/LO pair for the EX stage.
// A single launch runs for a fixed number of cycles (per op class) behind a
// down-counter; the result is committed to HI/LO on the final RUN edge unless
// the operation is flushed or reset first.
module md_unit_param #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int MAC_EN      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             we,
  input  logic             hilo,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int LMAX  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (LMAX < 2) ? 1 : $clog2(LMAX + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               op_valid;
  logic               op_is_div;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] divres;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] res;

  // Full-width product; operands are sign- or zero-extended before multiplying
  // so the low 2*WIDTH bits are the exact signed or unsigned product.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             uns);
    logic signed [2*WIDTH-1:0] ea;
    logic signed [2*WIDTH-1:0] eb;
    ea = uns ? $signed({{WIDTH{1'b0}}, a}) : $signed({{WIDTH{a[WIDTH-1]}}, a});
    eb = uns ? $signed({{WIDTH{1'b0}}, b}) : $signed({{WIDTH{b[WIDTH-1]}}, b});
    return $unsigned(ea * eb);
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes and
  // reapplies signs: quotient truncates toward zero, remainder follows the
  // dividend. most-negative / -1 wraps naturally to {0, most-negative}.
  // Divide by zero yields {dividend, all ones}.
  function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             uns);
    logic [WIDTH-1:0] ma, mb, q, r;
    logic             neg_q, neg_r;
    if (b == '0) begin
      return {a, {WIDTH{1'b1}}};
    end
    neg_q = !uns && (a[WIDTH-1] ^ b[WIDTH-1]);
    neg_r = !uns && a[WIDTH-1];
    ma    = (!uns && a[WIDTH-1]) ? (~a + 1'b1) : a;
    mb    = (!uns && b[WIDTH-1]) ? (~b + 1'b1) : b;
    q     = ma / mb;
    r     = ma % mb;
    if (neg_q) q = ~q + 1'b1;
    if (neg_r) r = ~r + 1'b1;
    return {r, q};
  endfunction

  assign op_valid  = !op[2] || (MAC_EN != 0);
  assign op_is_div = (op[2:1] == 2'b01);

  // Result selection from the latched operands and the current HI/LO.
  always_comb begin
    prod   = mul_full(a_q, b_q, op_q[0]);
    divres = div_full(a_q, b_q, op_q[0]);
    acc    = {hi_q, lo_q};
    res    = prod;
    case (op_q)
      3'b000, 3'b001: res = prod;
      3'b010, 3'b011: res = divres;
      3'b100, 3'b101: res = acc + prod;
      default:        res = acc - prod;
    endcase
  end

  // Next-state logic: launch, MTHI/MTLO write, countdown, commit and flush.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start && !flush && op_valid) begin
          state_d = RUN;
          cnt_d   = op_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          op_d    = op;
          a_d     = d1;
          b_d     = d2;
        end else if (we && !start && !flush) begin
          if (hilo) hi_d = d1;
          else      lo_d = d1;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d      = IDLE;
          cnt_d        = '0;
          {hi_d, lo_d} = res;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand latches; only meaningful while RUN, so no reset is needed.
  always_ff @(posedge clk) begin
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit_param.sv
// Bench for md_unit_param: a deadline-based behavioural model checked every
// cycle, plus hand-computed literal expectations for the directed vectors.
module tb_md_unit_param;

  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start0 = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] d1 = '0, d2 = '0;
  logic        we = 1'b0, we0 = 1'b0;
  logic        hilo = 1'b0;
  logic        flush = 1'b0;
  logic        busy, busy0;
  logic [31:0] hi, lo, hi0, lo0;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  md_unit_param #(.WIDTH(32), .MULT_CYCLES(ML), .DIV_CYCLES(DL), .MAC_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .d1(d1), .d2(d2),
    .we(we), .hilo(hilo), .flush(flush), .busy(busy), .hi(hi), .lo(lo)
  );

  md_unit_param #(.WIDTH(32), .MULT_CYCLES(ML), .DIV_CYCLES(DL), .MAC_EN(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .op(op), .d1(d1), .d2(d2),
    .we(we0), .hilo(hilo), .flush(flush), .busy(busy0), .hi(hi0), .lo(lo0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] acc);
    longint      sa, sb;
    logic [63:0] ps, pu, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = 64'(sa * sb);
    pu = {32'd0, a} * {32'd0, b};
    r  = '0;
    case (o)
      3'd0: r = ps;
      3'd1: r = pu;
      3'd2: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      3'd3: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      3'd4: r = acc + ps;
      3'd5: r = acc + pu;
      3'd6: r = acc - ps;
      default: r = acc - pu;
    endcase
    return r;
  endfunction

  logic [31:0] mhi = '0, mlo = '0;
  logic        mbusy = 1'b0, mvalid = 1'b0;
  logic [63:0] mres = '0;
  int          cyc = 0, mdone = 0;

  // The model commits at an absolute cycle deadline fixed at launch.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mhi = '0; mlo = '0; mbusy = 1'b0; mvalid = 1'b1;
    end else if (mbusy) begin
      if (flush) mbusy = 1'b0;
      else if (cyc == mdone) begin
        {mhi, mlo} = mres;
        mbusy = 1'b0;
      end
    end else if (start && !flush) begin
      mres  = model_result(op, d1, d2, {mhi, mlo});
      mdone = cyc + ((op == 3'd2 || op == 3'd3) ? DL : ML);
      mbusy = 1'b1;
    end else if (we && !start && !flush) begin
      if (hilo) mhi = d1;
      else      mlo = d1;
    end
  end

  // Per-cycle comparison of the main DUT against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      check("model busy", busy, mbusy);
      check("model hi", hi, mhi);
      check("model lo", lo, mlo);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; d1 = a; d2 = b;
    step();
    start = 1'b0;
  endtask

  task automatic wr(input logic h, input logic [31:0] v);
    we = 1'b1; hilo = h; d1 = v;
    step();
    we = 1'b0;
  endtask

  task automatic run_wait(output int n);
    bit done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
      n++;
    end
    if (!done) begin
      chk_cnt++;
      $display("FAIL busy timeout: still busy after %0d cycles, required idle", n);
    end
    step();
  endtask

  int n;

  initial begin
    step();
    step();
    rst = 1'b0;
    check("reset busy", busy, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy0", busy0, 0);

    // MULT -3 * 5
    launch(3'd0, 32'hFFFF_FFFD, 32'd5);
    run_wait(n);
    check("mult busy cycles", n, ML);
    check("mult hi", hi, 32'hFFFF_FFFF);
    check("mult lo", lo, 32'hFFFF_FFF1);

    // MULTU 0xFFFFFFFF * 2
    launch(3'd1, 32'hFFFF_FFFF, 32'd2);
    run_wait(n);
    check("multu hi", hi, 32'h0000_0001);
    check("multu lo", lo, 32'hFFFF_FFFE);

    // DIV -7 / 2
    launch(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_wait(n);
    check("div busy cycles", n, DL);
    check("div lo", lo, 32'hFFFF_FFFD);
    check("div hi", hi, 32'hFFFF_FFFF);

    // DIVU by zero
    launch(3'd3, 32'h0000_1234, 32'd0);
    run_wait(n);
    check("divu0 busy cycles", n, DL);
    check("divu0 lo", lo, 32'hFFFF_FFFF);
    check("divu0 hi", hi, 32'h0000_1234);

    // DIV by zero and signed overflow
    launch(3'd2, 32'hFFFF_FFF9, 32'd0);
    run_wait(n);
    check("div0 lo", lo, 32'hFFFF_FFFF);
    check("div0 hi", hi, 32'hFFFF_FFF9);
    launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_wait(n);
    check("divovf lo", lo, 32'h8000_0000);
    check("divovf hi", hi, 32'h0000_0000);

    // MADDU / MSUB around the HI/LO carry boundary
    wr(1'b1, 32'h0);
    wr(1'b0, 32'hFFFF_FFFF);
    check("preload hi", hi, 32'h0);
    check("preload lo", lo, 32'hFFFF_FFFF);
    launch(3'd5, 32'd1, 32'd1);
    run_wait(n);
    check("maddu busy cycles", n, ML);
    check("maddu hi", hi, 32'h1);
    check("maddu lo", lo, 32'h0);
    launch(3'd6, 32'd1, 32'd1);
    run_wait(n);
    check("msub hi", hi, 32'h0);
    check("msub lo", lo, 32'hFFFF_FFFF);

    // Flush in RUN cycle 4 of a divide
    wr(1'b1, 32'hA);
    wr(1'b0, 32'hB);
    launch(3'd2, 32'd100, 32'd7);
    step(); step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("flush busy", busy, 0);
    check("flush hi", hi, 32'hA);
    check("flush lo", lo, 32'hB);
    step();

    // start together with flush: no launch
    start = 1'b1; flush = 1'b1; op = 3'd0; d1 = 32'd3; d2 = 32'd3;
    step();
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("start+flush busy", busy, 0);
    step();

    // we together with flush: no write
    we = 1'b1; flush = 1'b1; hilo = 1'b0; d1 = 32'h5;
    step();
    we = 1'b0; flush = 1'b0;
    check("we+flush lo", lo, 32'hB);

    // flush on the commit edge
    launch(3'd0, 32'd2, 32'd2);
    repeat (ML - 1) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush commit busy", busy, 0);
    check("flush commit lo", lo, 32'hB);
    step();

    // start and we during busy are ignored
    launch(3'd0, 32'd6, 32'd7);
    step();
    start = 1'b1; op = 3'd2; we = 1'b1; hilo = 1'b0; d1 = 32'h55; d2 = 32'd9;
    step();
    start = 1'b0; we = 1'b0;
    run_wait(n);
    check("busy-ignore busy cycles", n, ML - 2);
    check("busy-ignore hi", hi, 32'h0);
    check("busy-ignore lo", lo, 32'd42);

    // start and we in the same idle cycle: only the op runs
    start = 1'b1; op = 3'd1; d1 = 32'd2; d2 = 32'd3; we = 1'b1; hilo = 1'b1;
    step();
    start = 1'b0; we = 1'b0;
    run_wait(n);
    check("start+we busy cycles", n, ML);
    check("start+we hi", hi, 32'h0);
    check("start+we lo", lo, 32'd6);

    // reset in RUN cycle 2
    launch(3'd0, 32'h10, 32'h10);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst busy", busy, 0);
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    repeat (12) step();
    check("rst no commit lo", lo, 0);
    check("rst no commit hi", hi, 0);

    // MAC_EN=0 instance: MADD is a no-op, MULT still works
    we0 = 1'b1; hilo = 1'b1; d1 = 32'h77;
    step();
    hilo = 1'b0; d1 = 32'h88;
    step();
    we0 = 1'b0;
    start0 = 1'b1; op = 3'd4; d1 = 32'd3; d2 = 32'd4;
    step();
    start0 = 1'b0;
    for (int i = 0; i < ML + 2; i++) begin
      @(negedge clk);
      check("mac_en0 busy", busy0, 0);
    end
    step();
    check("mac_en0 hi", hi0, 32'h77);
    check("mac_en0 lo", lo0, 32'h88);
    start0 = 1'b1; op = 3'd0; d1 = 32'd3; d2 = 32'd4;
    step();
    start0 = 1'b0;
    @(negedge clk);
    check("mac_en0 mult busy", busy0, 1);
    repeat (ML + 1) step();
    check("mac_en0 mult hi", hi0, 32'h0);
    check("mac_en0 mult lo", lo0, 32'd12);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
- Parametrised multiply/divide unit with its own HI/LO register pair, operating in the EX stage of the five-stage MIPS pipeline.
- Successor to the fixed 32-bit mult/div block. Adds:
  - configurable data width and per-class latencies;
  - multiply-accumulate and multiply-subtract (MADD/MADDU/MSUB/MSUBU);
  - defined divide-by-zero results;
  - a flush input, so an interrupt can cancel an in-flight operation without corrupting HI/LO.
- The hazard unit stalls on busy or start, as it does today.

Parameters:
- WIDTH, 32: operand, HI and LO width.
- MULT_CYCLES, 5: busy cycles for all multiply-class ops. Must be ≥ 1.
- DIV_CYCLES, 10: busy cycles for DIV/DIVU. Must be ≥ 1.
- MAC_EN, 1: when 0, ops 100–111 are treated as no-ops (start ignored, busy stays 0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle launch strobe.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- d1  in  WIDTH  rs operand (already forwarded).
- d2  in  WIDTH  rt operand (already forwarded).
- we  in  1  MTHI/MTLO write strobe.
- hilo  in  1  write target: 1 = HI, 0 = LO.
- flush  in  1  abort in-flight op or pending launch; driven by IntReq.
- busy  out  1  operation in progress.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (synchronous, rst=1 at an edge): hi=0, lo=0, busy=0, counter=0, state IDLE. Reset overrides every other input, including mid-operation; any partial result is discarded.
- State machine:
  - IDLE: start=1, flush=0 and a valid op → latch d1, d2 and op into internal registers, load counter with L, go to RUN. busy=1 from the next cycle.
  - RUN: counter decrements each cycle. On the edge where counter reaches 1, commit the result to hi/lo, set busy=0 and return to IDLE.
  - Latency: start sampled at edge t → busy high for cycles t+1 … t+L; hi/lo show the new result from edge t+L.
  - L = MULT_CYCLES for ops 000, 001 and 1xx; L = DIV_CYCLES for 010 and 011.
- Operands are latched at start. Changes on d1/d2 during RUN have no effect.
- start while busy=1 is ignored; no queueing.
- we:
  - Applies only in IDLE with start=0. In that case hi or lo (per hilo) takes the d1 value at that edge.
  - Ignored while busy, and ignored on a cycle where start=1 (start wins).
- flush:
  - In RUN: return to IDLE at that edge; busy=0 from the next cycle; hi/lo keep their pre-start values.
  - Same cycle as start: the launch is suppressed.
  - Same cycle as we: the write is suppressed.
  - Same cycle as the final (commit) RUN cycle: flush wins, no commit.
- Arithmetic:
  - MULT/MULTU: {hi,lo} = 2·WIDTH-bit signed/unsigned product.
  - MADD(U): {hi,lo} = {hi,lo} + product. MSUB(U): {hi,lo} = {hi,lo} − product. Both modulo 2^(2·WIDTH), using the hi/lo values at commit time (unchanged during RUN).
  - DIV: lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (both DIV and DIVU): lo = all ones, hi = d1. Commits after DIV_CYCLES like any other divide.
  - Signed overflow, most-negative ÷ −1: lo = most-negative value, hi = 0.
- Internal implementation (iterative or behavioural with a delay counter) is free, provided the cycle timing above holds exactly.
- hi, lo and busy are registered outputs with no combinational path from inputs.

Test Plan:
- MULT, d1=0xFFFFFFFD (−3), d2=5 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1. Repeat with MULTU, d1=0xFFFFFFFF, d2=2 → hi=0x00000001, lo=0xFFFFFFFE.
- DIV, d1=0xFFFFFFF9 (−7), d2=2 → busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, d1=0x1234, d2=0 → lo=0xFFFFFFFF, hi=0x00001234.
- Preload via we: hi=0, lo=0xFFFFFFFF. Then MADDU, d1=1, d2=1 → hi=1, lo=0. Then MSUB, d1=1, d2=1 → hi=0, lo=0xFFFFFFFF.
- Preload hi=0xA, lo=0xB. Start DIV, assert flush in RUN cycle 4 → busy=0 the next cycle, hi=0xA and lo=0xB unchanged. Assert start+flush together → busy stays 0.
- During busy: start (new op) and we with d1=0x55 → both ignored; the original result commits on schedule. start and we in the same IDLE cycle → only the op runs.
- rst in RUN cycle 2 → the next cycle shows busy=0, hi=0, lo=0, and no later commit occurs. With MAC_EN=0, start with op=100 → busy stays 0 and hi/lo are unchanged.
